// File: rtl/string_op_sequencer.sv
// Word-serial sequencer for the string accelerator: strcmp, strlen(A) and strncmp over the
// StringA/StringB word buffers, one 32-bit word per FETCH/CMP round trip.
module string_op_sequencer #(
    parameter int unsigned MAX_WORDS = 8,
    localparam int unsigned AW = $clog2(MAX_WORDS),
    localparam int unsigned IW = $clog2(4 * MAX_WORDS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [IW-1:0] len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   a_word,
    input  logic [31:0]   b_word,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result,
    output logic [IW-1:0] index,
    output logic          overflow,
    output logic          error
);

    localparam logic [IW-1:0] NumBytes = IW'(4 * MAX_WORDS);
    localparam logic [AW-1:0] LastWord = AW'(MAX_WORDS - 1);
    localparam logic [1:0] OpStrlen  = 2'd1;
    localparam logic [1:0] OpStrncmp = 2'd2;
    localparam logic [1:0] OpRsvd    = 2'd3;

    typedef enum logic [1:0] {StIdle, StFetch, StCmp, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] len_q, len_d;
    logic          clamp_q, clamp_d;

    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   result_q, result_d;
    logic [IW-1:0] index_q, index_d;
    logic          overflow_q, overflow_d;
    logic          error_q, error_d;

    // Lane scan of the current word; lowest terminating lane wins.
    logic          hit;
    logic [IW-1:0] hit_pos;
    logic [8:0]    hit_diff;
    logic [IW-1:0] limit_pos;
    logic [7:0]    a_b, b_b;
    logic [IW-1:0] pos;
    logic          term;

    always_comb begin
        hit       = 1'b0;
        hit_pos   = '0;
        hit_diff  = '0;
        limit_pos = len_q - IW'(1);
        a_b       = '0;
        b_b       = '0;
        pos       = '0;
        term      = 1'b0;
        for (int l = 0; l < 4; l++) begin
            a_b  = a_word[8*l +: 8];
            b_b  = b_word[8*l +: 8];
            pos  = {1'b0, word_q, 2'(l)};
            term = (a_b == 8'd0);
            if (op_q != OpStrlen) term = term | (a_b != b_b);
            // A clamped limit is the buffer end, which reports as overflow instead.
            if (op_q == OpStrncmp && !clamp_q && pos == limit_pos) term = 1'b1;
            if (term && !hit) begin
                hit      = 1'b1;
                hit_pos  = pos;
                hit_diff = {1'b0, a_b} - {1'b0, b_b};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        op_d    = op_q;
        len_d   = len_q;
        clamp_d = clamp_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    len_d   = len;
                    clamp_d = (len > NumBytes);
                    word_d  = '0;
                    if (op == OpRsvd || (op == OpStrncmp && len == '0)) state_d = StDone;
                    else                                                state_d = StFetch;
                end
            end
            StFetch: state_d = StCmp;
            StCmp: begin
                if (hit || word_q == LastWord) begin
                    state_d = StDone;
                end else begin
                    word_d  = word_q + AW'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en_d    = (state_d == StFetch);
        rd_addr_d  = word_d;
        busy_d     = (state_d == StFetch) || (state_d == StCmp);
        done_d     = (state_d == StDone);
        result_d   = result_q;
        index_d    = index_q;
        overflow_d = overflow_q;
        error_d    = error_q;
        if (state_q == StIdle && state_d == StDone) begin
            result_d   = '0;
            index_d    = '0;
            overflow_d = 1'b0;
            error_d    = (op == OpRsvd);
        end else if (state_q == StCmp && state_d == StDone) begin
            error_d = 1'b0;
            if (hit) begin
                overflow_d = 1'b0;
                index_d    = hit_pos;
                result_d   = (op_q == OpStrlen) ? 32'(hit_pos) : {{23{hit_diff[8]}}, hit_diff};
            end else begin
                overflow_d = 1'b1;
                index_d    = NumBytes;
                result_d   = (op_q == OpStrlen) ? 32'(NumBytes) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            op_q       <= '0;
            len_q      <= '0;
            clamp_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            index_q    <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            word_q     <= word_d;
            op_q       <= op_d;
            len_q      <= len_d;
            clamp_q    <= clamp_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            index_q    <= index_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign index    = index_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule

// File: tb/tb_string_op_sequencer.sv
// Self-checking bench for string_op_sequencer: directed cases plus random strings, checked
// against a byte-level string model.
module tb_string_op_sequencer;

    localparam int MW = 8;
    localparam int NB = 4 * MW;
    localparam int IW = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [IW-1:0] len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   a_word;
    logic [31:0]   b_word;
    logic          busy;
    logic          done;
    logic [31:0]   result;
    logic [IW-1:0] index;
    logic          overflow;
    logic          error;

    logic [7:0] amem [NB];
    logic [7:0] bmem [NB];

    int n_checks = 0;
    int n_errors = 0;

    string_op_sequencer #(.MAX_WORDS(MW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .len     (len),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .a_word  (a_word),
        .b_word  (b_word),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .index   (index),
        .overflow(overflow),
        .error   (error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a_at(int w);
        return {amem[4*w+3], amem[4*w+2], amem[4*w+1], amem[4*w]};
    endfunction

    function automatic logic [31:0] b_at(int w);
        return {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]};
    endfunction

    // Buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_word <= a_at(int'(rd_addr));
            b_word <= b_at(int'(rd_addr));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // C-library semantics over the byte arrays.
    task automatic model(input logic [1:0] o, input int l, output logic [31:0] res,
                         output int idx, output bit ovf, output bit err, output int lat,
                         output int nrd);
        bit use_lim;
        err = (o == 2'd3);
        res = 0; idx = 0; ovf = 0; lat = 1; nrd = 0;
        if (o == 2'd3 || (o == 2'd2 && l == 0)) return;
        use_lim = (o == 2'd2) && (l <= NB);
        for (int i = 0; i < NB; i++) begin
            int  a = int'(amem[i]);
            int  b = int'(bmem[i]);
            bit  t;
            if (o == 2'd1) t = (a == 0);
            else           t = (a != b) || (a == 0) || (use_lim && i == l - 1);
            if (t) begin
                res = (o == 2'd1) ? 32'(i) : 32'(a - b);
                idx = i;
                lat = 2 * (i / 4) + 3;
                nrd = i / 4 + 1;
                return;
            end
        end
        ovf = 1;
        idx = NB;
        res = (o == 2'd1) ? 32'(NB) : 32'd0;
        lat = 2 * MW + 1;
        nrd = MW;
    endtask

    task automatic load(input string sa, input string sb);
        for (int i = 0; i < NB; i++) begin
            amem[i] = 8'h5a;
            bmem[i] = 8'h5a;
        end
        for (int i = 0; i < sa.len(); i++) amem[i] = sa[i];
        amem[sa.len()] = 8'h00;
        for (int i = 0; i < sb.len(); i++) bmem[i] = sb[i];
        bmem[sb.len()] = 8'h00;
    endtask

    // Issues one operation and follows it to done; poke_at>0 pulses a stray start mid-flight.
    task automatic run_op(input logic [1:0] o, input int l, input int poke_at);
        logic [31:0] e_res;
        int e_idx, e_lat, e_nrd, c, nreads;
        bit e_ovf, e_err, got_done;
        model(o, l, e_res, e_idx, e_ovf, e_err, e_lat, e_nrd);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        len   = IW'(l);
        @(negedge clk);
        start    = 1'b0;
        c        = 1;
        nreads   = 0;
        got_done = 0;
        while (c <= 40 && !got_done) begin
            start = (c == poke_at);
            op    = (c == poke_at) ? 2'd3 : o;
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(nreads));
                check("rd_cycle", 32'(c), 32'(1 + 2 * nreads));
                nreads++;
            end
            if (c == 1 && e_lat > 1) check("busy_first", 32'(busy), 32'd1);
            if (done) begin
                got_done = 1;
                check("done_cycle", 32'(c), 32'(e_lat));
                check("busy_at_done", 32'(busy), 32'd0);
                check("result", result, e_res);
                check("index", 32'(index), 32'(e_idx));
                check("overflow", 32'(overflow), 32'(e_ovf));
                check("error", 32'(error), 32'(e_err));
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
        check("nreads", 32'(nreads), 32'(e_nrd));
        check("done_pulse", 32'(done), 32'd0);
        @(negedge clk);
        check("result_hold", result, e_res);
        check("index_hold", 32'(index), 32'(e_idx));
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = '0;
        len    = '0;
        a_word = '0;
        b_word = '0;
        load("", "");
        repeat (3) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;

        load("abc", "abc");
        run_op(2'd0, 0, 0);
        load("abcde", "abcdf");
        run_op(2'd0, 0, 0);
        load("", "");
        amem[0] = 8'hff;
        bmem[0] = 8'h01;
        run_op(2'd0, 0, 0);
        for (int i = 0; i < NB; i++) amem[i] = "x";
        run_op(2'd1, 0, 0);
        run_op(2'd2, 0, 0);
        load("abX", "abY");
        run_op(2'd2, 2, 0);
        run_op(2'd3, 0, 0);
        for (int i = 0; i < NB; i++) begin
            amem[i] = "x";
            bmem[i] = "x";
        end
        run_op(2'd2, 32, 0);
        run_op(2'd2, 40, 0);
        run_op(2'd1, 0, 4);
        run_op(2'd0, 0, 16);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_index", 32'(index), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (done || rd_en) check("abort_quiet", {30'd0, done, rd_en}, 32'd0);
            @(negedge clk);
        end
        load("abc", "abc");
        run_op(2'd0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int r;
            for (int i = 0; i < NB; i++) begin
                r = int'($urandom_range(0, 15));
                amem[i] = (r == 0) ? 8'h00 : (r < 8) ? "a" : 8'($urandom_range(1, 255));
                bmem[i] = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(0, 255)) : amem[i];
            end
            run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
